// File: rtl/swt_debounce.sv
// swt_debounce: synchronise and debounce 16 slide switches, emitting clean state, edge strobes and an event count.
module swt_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int CNT_W = 20,
  parameter int EVT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [15:0]      swt,
  output logic [15:0]      swt_clean,
  output logic [15:0]      swt_rise,
  output logic [15:0]      swt_fall,
  output logic             change,
  output logic [EVT_W-1:0] evt_cnt
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  logic [15:0] s1_q, s2_q, clean_q, clean_d, rise_q, rise_d, fall_q, fall_d, hit, flip;
  logic [15:0][CNT_W-1:0] cnt_q, cnt_d;
  logic change_q, change_d;
  logic [EVT_W-1:0] evt_q, evt_d;
  // a bit flips only on the edge where its mismatch run reaches the full length
  for (genvar g = 0; g < 16; g++) begin : g_bit
    assign hit[g] = cnt_q[g] == LAST;
    assign cnt_d[g] = (s2_q[g] == clean_q[g] || hit[g]) ? '0 : cnt_q[g] + CNT_W'(1);
  end
  always_comb begin
    flip = (s2_q ^ clean_q) & hit;
    clean_d = clean_q ^ flip;
    rise_d = flip & s2_q;
    fall_d = flip & ~s2_q;
    change_d = |flip;
    evt_d = evt_q + EVT_W'(change_d);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s1_q <= '0;
      s2_q <= '0;
      cnt_q <= '0;
      clean_q <= '0;
      rise_q <= '0;
      fall_q <= '0;
      change_q <= 1'b0;
      evt_q <= '0;
    end else begin
      s1_q <= swt;
      s2_q <= s1_q;
      cnt_q <= cnt_d;
      clean_q <= clean_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
      change_q <= change_d;
      evt_q <= evt_d;
    end
  assign swt_clean = clean_q;
  assign swt_rise = rise_q;
  assign swt_fall = fall_q;
  assign change = change_q;
  assign evt_cnt = evt_q;
endmodule

// File: tb/tb_swt_debounce.sv
// tb_swt_debounce: directed vectors and hand sequences for swt_debounce with a 4-cycle debounce and 4-bit event counter.
module tb_swt_debounce;
  localparam int DC = 4, CW = 3, EW = 4;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [15:0] swt = '0;
  logic [15:0] swt_clean, swt_rise, swt_fall;
  logic change;
  logic [EW-1:0] evt_cnt;
  int n_cmp = 0, n_bad = 0;
  typedef struct packed {
    logic [15:0] sw, cl, ri, fa;
    logic ch;
    logic [3:0] ev;
  } vec_t;
  vec_t tv[$];
  int bb[9] = '{1, 0, 1, 1, 0, 1, 1, 1, 1};
  always #5 clk = ~clk;
  swt_debounce #(.DEBOUNCE_CYCLES(DC), .CNT_W(CW), .EVT_W(EW)) dut (
    .clk(clk), .rst_n(rst_n), .swt(swt), .swt_clean(swt_clean), .swt_rise(swt_rise),
    .swt_fall(swt_fall), .change(change), .evt_cnt(evt_cnt)
  );
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string nm, input logic [15:0] cl, ri, fa, input logic ch, input logic [3:0] ev);
    n_cmp++;
    if ({swt_clean, swt_rise, swt_fall, change, evt_cnt} !== {cl, ri, fa, ch, ev}) begin
      n_bad++;
      $display("FAIL %s: got clean=%h rise=%h fall=%h change=%b evt=%0d, want clean=%h rise=%h fall=%h change=%b evt=%0d",
               nm, swt_clean, swt_rise, swt_fall, change, evt_cnt, cl, ri, fa, ch, ev);
    end
  endtask
  task automatic add(input logic [15:0] sw, cl, ri, fa, input logic ch, input logic [3:0] ev);
    tv.push_back('{sw, cl, ri, fa, ch, ev});
  endtask
  initial begin
    // switches high through reset, first edge after release is k
    swt = 16'hFFFF;
    repeat (2) step();
    chk("reset_hold", 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("startup_wait%0d", i), 0, 0, 0, 0, 0);
    end
    step();
    chk("startup_rise", 16'hFFFF, 16'hFFFF, 0, 1, 1);
    step();
    chk("startup_after", 16'hFFFF, 0, 0, 0, 1);
    rst_n = 1'b0;
    #1;
    chk("async_reset", 0, 0, 0, 0, 0);
    swt = '0;
    repeat (2) step();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) add(16'h0001, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) add(16'h0000, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) add(16'h0001, 0, 0, 0, 0, 0);
    add(16'h0000, 0, 0, 0, 0, 0);
    add(16'h0000, 16'h0001, 16'h0001, 0, 1, 1);
    for (int i = 0; i < 3; i++) add(16'h0000, 16'h0001, 0, 0, 0, 1);
    add(16'h0000, 0, 0, 16'h0001, 1, 2);
    add(16'h0000, 0, 0, 0, 0, 2);
    for (int i = 0; i < 5; i++) add(16'h0020, 0, 0, 0, 0, 2);
    add(16'h0020, 16'h0020, 16'h0020, 0, 1, 3);
    add(16'h0020, 16'h0020, 0, 0, 0, 3);
    for (int i = 0; i < 5; i++) add(16'h0008, 16'h0020, 0, 0, 0, 3);
    add(16'h0008, 16'h0008, 16'h0008, 16'h0020, 1, 4);
    add(16'h0008, 16'h0008, 0, 0, 0, 4);
    for (int i = 0; i < 9; i++) add(bb[i] != 0 ? 16'h0088 : 16'h0008, 16'h0008, 0, 0, 0, 4);
    add(16'h0088, 16'h0008, 0, 0, 0, 4);
    add(16'h0088, 16'h0088, 16'h0080, 0, 1, 5);
    add(16'h0088, 16'h0088, 0, 0, 0, 5);
    for (int i = 0; i < tv.size(); i++) begin
      swt = tv[i].sw;
      step();
      chk($sformatf("vec%0d", i), tv[i].cl, tv[i].ri, tv[i].fa, tv[i].ch, tv[i].ev);
    end
    // event counter wrap: sixteen spaced toggles of bit 2
    rst_n = 1'b0;
    #1;
    swt = '0;
    step();
    rst_n = 1'b1;
    for (int t = 1; t <= 16; t++) begin
      swt[2] = ~swt[2];
      repeat (5) step();
      chk($sformatf("toggle%0d_wait", t), ~swt & 16'h0004, 0, 0, 0, 4'(t - 1));
      step();
      chk($sformatf("toggle%0d", t), swt, swt, ~swt & 16'h0004, 1, 4'(t));
      repeat (2) step();
    end
    // reset while bit 9 is mid-count discards the count
    swt = 16'h0001;
    repeat (6) step();
    chk("bit0_rise", 16'h0001, 16'h0001, 0, 1, 1);
    step();
    swt = 16'h0201;
    repeat (4) step();
    rst_n = 1'b0;
    #1;
    chk("midcount_reset", 0, 0, 0, 0, 0);
    repeat (2) step();
    chk("midcount_hold", 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("recount%0d", i), 0, 0, 0, 0, 0);
    end
    step();
    chk("recount_rise", 16'h0201, 16'h0201, 0, 1, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
